// File: rtl/uart_receiver.sv
// uart_receiver
// ---------------------------------------------------------------------------
// 8N1 UART receiver with 16x oversampling and a valid/ready byte hand-off.
//
// Parameters
//   CLK_DIV    clk cycles per oversample tick (>= 2); 16 ticks make one bit.
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-high
//   rx         serial line, idle high
//   data_out   last correctly framed byte (changes only on byte completion)
//   data_valid high while data_out holds a byte not yet consumed
//   data_ready consumer acknowledge; consumes on a clk with data_valid high
//   frame_err  one-clk pulse when a stop bit is sampled low
//   overrun    one-clk pulse when a byte completes while the previous one
//              is still unconsumed (the new byte is dropped)
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLK_DIV = 651
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             rx_p0;
  logic             rx_p1;
  logic             rx_s;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  logic [3:0]       smp_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;

  logic             shift_en;
  logic             byte_done;
  logic             stop_fail;

  // Stage p0/p1: two-flop synchronizer; idle level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  assign rx_s = rx_p1;

  // Free-running oversample tick generator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Start is qualified at sample 7 (mid start bit); from then on every
  // 16th tick lands in the middle of the next bit.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    stop_fail = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) state_nxt = START;
        end
        START: begin
          if (smp_cnt == 4'd7) state_nxt = rx_s ? IDLE : DATA;
        end
        DATA: begin
          if (smp_cnt == 4'd15) begin
            shift_en = 1'b1;
            if (bit_cnt == 3'd7) state_nxt = STOP;
          end
        end
        STOP: begin
          if (smp_cnt == 4'd15) begin
            if (rx_s) begin
              byte_done = 1'b1;
              state_nxt = IDLE;
            end else begin
              stop_fail = 1'b1;
              state_nxt = BREAK;
            end
          end
        end
        BREAK: begin
          // Wait for the line to return high so a held-low line reports once.
          if (rx_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Sample and bit counters restart on every state change; sample counter
  // wraps 15 -> 0 naturally between data bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp_cnt <= '0;
      bit_cnt <= '0;
    end else if (state_nxt != state) begin
      smp_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      if (tick)     smp_cnt <= smp_cnt + 4'd1;
      if (shift_en) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg[bit_cnt] <= rx_s;
    end
  end

  // Output hand-off: a completed byte is published only if the slot is free
  // or being consumed on the same clk; otherwise it is dropped as overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_fail;
      overrun   <= 1'b0;
      if (byte_done) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift_reg;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
// Directed bench for uart_receiver with CLK_DIV=4 (one bit = 64 clk).
// Inputs are driven 1 time unit after each rising edge; pulse outputs are
// counted on the falling edge.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad = 0;

  int   cyc = 0;
  int   fe_cnt = 0;
  int   ov_cnt = 0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;
  int   rise_cyc = 0;
  logic vld_prev = 1'b0;

  int start_cyc = 0;
  int d = 0;
  int lat = 0;
  int fe0 = 0;
  int ov0 = 0;
  int rise0 = 0;
  int fall0 = 0;

  uart_receiver #(.CLK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
    if (data_valid === 1'b1 && vld_prev === 1'b0) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (data_valid === 1'b0 && vld_prev === 1'b1) fall_cnt <= fall_cnt + 1;
    vld_prev <= data_valid;
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    fe0   = fe_cnt;
    ov0   = ov_cnt;
    rise0 = rise_cnt;
    fall0 = fall_cnt;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    start_cyc = cyc;
    cycles(64);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(64);
    end
    rx = stop;
    cycles(64);
  endtask

  task automatic pulse_ready();
    data_ready = 1'b1;
    cycles(1);
    data_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    cycles(4);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b0;
    cycles(8);

    // 0xA5, no acknowledge: latency, data, no error pulses
    snap();
    send_frame(8'hA5, 1'b1);
    cycles(16);
    check("a5_valid", 32'(data_valid), 32'h1);
    check("a5_data", 32'(data_out), 32'hA5);
    check("a5_ferr_pulses", 32'(fe_cnt - fe0), 32'd0);
    check("a5_ovr_pulses", 32'(ov_cnt - ov0), 32'd0);
    check("a5_valid_rises", 32'(rise_cnt - rise0), 32'd1);
    lat = rise_cyc - start_cyc;
    total++;
    assert (lat >= 610 && lat <= 616) else begin
      bad++;
      $error("FAIL a5_latency: observed=%0d expected=610..616 clk from start edge", lat);
    end
    pulse_ready();
    check("a5_consumed_valid", 32'(data_valid), 32'h0);
    check("a5_consumed_data", 32'(data_out), 32'hA5);
    cycles(16);

    // 0x3C then 0x81 unacknowledged: one overrun, old byte kept
    snap();
    send_frame(8'h3C, 1'b1);
    cycles(16);
    check("3c_valid", 32'(data_valid), 32'h1);
    check("3c_data", 32'(data_out), 32'h3C);
    send_frame(8'h81, 1'b1);
    cycles(16);
    check("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
    check("ovr_data_kept", 32'(data_out), 32'h3C);
    check("ovr_valid", 32'(data_valid), 32'h1);
    check("ovr_valid_rises", 32'(rise_cnt - rise0), 32'd1);
    pulse_ready();
    check("ack_valid_low", 32'(data_valid), 32'h0);
    check("ack_data_hold", 32'(data_out), 32'h3C);
    // acknowledge with nothing pending is ignored
    pulse_ready();
    cycles(2);
    check("idle_ack_valid", 32'(data_valid), 32'h0);
    check("idle_ack_data", 32'(data_out), 32'h3C);
    check("idle_ack_rises", 32'(rise_cnt - rise0), 32'd1);
    cycles(16);

    // Acknowledge on the exact completion clk of 0x81 while 0x3C pending.
    // Frames are multiples of 4 clk apart, so the divider phase repeats and
    // 0x81 completes at the same offset d measured on 0x3C.
    send_frame(8'h3C, 1'b1);
    d = rise_cyc - start_cyc;
    check("3c_b_valid", 32'(data_valid), 32'h1);
    check("3c_b_data", 32'(data_out), 32'h3C);
    snap();
    fork
      send_frame(8'h81, 1'b1);
      begin
        cycles(d - 1);
        data_ready = 1'b1;
        cycles(1);
        data_ready = 1'b0;
      end
    join
    cycles(16);
    check("same_clk_data", 32'(data_out), 32'h81);
    check("same_clk_valid", 32'(data_valid), 32'h1);
    check("same_clk_ovr", 32'(ov_cnt - ov0), 32'd0);
    check("same_clk_valid_falls", 32'(fall_cnt - fall0), 32'd0);
    pulse_ready();
    check("81_consumed", 32'(data_valid), 32'h0);
    cycles(16);

    // Short low glitch: rejected, receiver returns to idle
    snap();
    rx = 1'b0;
    cycles(20);
    rx = 1'b1;
    cycles(100);
    check("glitch_rises", 32'(rise_cnt - rise0), 32'd0);
    check("glitch_ferr", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_valid", 32'(data_valid), 32'h0);
    send_frame(8'hC3, 1'b1);
    cycles(16);
    check("post_glitch_data", 32'(data_out), 32'hC3);
    check("post_glitch_valid", 32'(data_valid), 32'h1);
    pulse_ready();
    cycles(16);

    // 0x55 with low stop, line held low 10 bit times, then 0x0F
    snap();
    send_frame(8'h55, 1'b0);
    cycles(640);
    rx = 1'b1;
    cycles(128);
    check("brk_ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("brk_valid", 32'(data_valid), 32'h0);
    check("brk_rises", 32'(rise_cnt - rise0), 32'd0);
    send_frame(8'h0F, 1'b1);
    cycles(16);
    check("brk_ferr_total", 32'(fe_cnt - fe0), 32'd1);
    check("0f_data", 32'(data_out), 32'h0F);
    check("0f_valid", 32'(data_valid), 32'h1);

    // Reset in the middle of 0xFF data bits (0x0F still pending)
    snap();
    rx = 1'b0;
    cycles(64);
    rx = 1'b1;
    cycles(128);
    reset = 1'b1;
    #1;
    check("midrst_async_data", 32'(data_out), 32'h00);
    check("midrst_async_valid", 32'(data_valid), 32'h0);
    check("midrst_async_ferr", 32'(frame_err), 32'h0);
    check("midrst_async_ovr", 32'(overrun), 32'h0);
    cycles(10);
    check("midrst_hold_data", 32'(data_out), 32'h00);
    check("midrst_hold_valid", 32'(data_valid), 32'h0);
    reset = 1'b0;
    cycles(512);
    check("midrst_no_byte", 32'(data_valid), 32'h0);
    rise0 = rise_cnt;
    send_frame(8'h12, 1'b1);
    cycles(16);
    check("12_data", 32'(data_out), 32'h12);
    check("12_valid", 32'(data_valid), 32'h1);
    check("12_rises", 32'(rise_cnt - rise0), 32'd1);
    check("midrst_ferr", 32'(fe_cnt - fe0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
